cam_capture_scaled: RTL
=======================

Name: cam_capture_scaled

Overview:
- Next-generation camera capture engine. Converts the OV7670 byte stream (RGB565, two bytes per pixel) into pixels of selectable colour depth, decimated in X and Y.
- Writes pixels into the dual-port frame buffer through an address/data/write-strobe interface.
- Adds continuous and single-shot frame modes, frame counting and error flags.
- Sits between the camera pins and buffer_ram_dp write port, clocked by the camera pclk.

Parameters:
- CAM_SCREEN_X, 160, stored frame width in pixels (after decimation)
- CAM_SCREEN_Y, 120, stored frame height in lines (after decimation)
- AW, 15, address width; must satisfy 2^AW >= CAM_SCREEN_X*CAM_SCREEN_Y
- DW, 12, output pixel width; minimum 12; unused MSBs driven 0
- DEC_X, 4, keep 1 of every DEC_X pixels per line (1..8)
- DEC_Y, 4, keep 1 of every DEC_Y lines per frame (1..8)

Ports:
- clk, in, 1, camera pclk; all logic on posedge
- rst, in, 1, asynchronous active-low reset
- vsync, in, 1, camera vertical sync; high = vertical blanking
- href, in, 1, camera line valid
- data, in, 8, camera byte
- fmt, in, 2, format select: 0 RGB111, 1 RGB332, 2 RGB444, 3 reserved (treated as RGB444); sampled at frame start
- single, in, 1, 1 = single-shot mode, 0 = continuous; sampled at frame start
- snap, in, 1, single-cycle arm pulse for single-shot mode
- mem_px_addr, out, AW, frame-buffer write address
- mem_px_data, out, DW, frame-buffer write data
- px_wr, out, 1, write strobe, one cycle per stored pixel
- frame_done, out, 1, one-cycle pulse at end of each captured frame
- frame_count, out, 8, captured frames, wraps 255->0
- busy, out, 1, high while in CAPTURE
- line_err, out, 1, sticky: line ended on an odd byte count; cleared at next frame start

Behaviour:
- Reset (async, rst=0): state WAIT_VS. All outputs 0, including addr, data, px_wr, counters and flags. A reset mid-frame abandons the frame and performs no further writes.
- WAIT_VS: wait for vsync=1, then go to ARMED.
- ARMED: on vsync falling edge (registered vsync 1->0), go to CAPTURE if single=0 or a snap was seen since the last capture; otherwise go to IDLE_SNAP. Latch fmt. Clear the address, row, column, byte-phase and decimation counters and line_err.
- IDLE_SNAP: a snap pulse (any state) sets the armed flag; leave for WAIT_VS when armed.
- CAPTURE, href=1 cycles:
  - byte phase 0 latches the high byte (R5, G6[5:3]).
  - byte phase 1 forms RGB565 and advances the source column.
  - A pixel is stored when source col % DEC_X == 0, source row % DEC_Y == 0, stored col < CAM_SCREEN_X and stored row < CAM_SCREEN_Y. Out-of-range pixels are dropped silently.
- Format mapping (LSB-aligned):
  - RGB111 = {R[4],G[5],B[4]}
  - RGB332 = {R[4:2],G[5:3],B[4:3]}
  - RGB444 = {R[4:1],G[5:2],B[4:1]}
- Write latency: mem_px_addr, mem_px_data and px_wr are registered and valid on the cycle after byte phase 1 is sampled. px_wr is high for exactly one cycle.
- mem_px_addr = stored_row*CAM_SCREEN_X + stored_col, generated by incrementing a counter (no multiplier). It holds its value between writes.
- href falling edge: reset the byte phase and source column, increment the source row. If the byte phase was 1, set line_err.
- End of frame (vsync rising edge in CAPTURE): pulse frame_done for one cycle, increment frame_count, clear the armed flag, go to WAIT_VS→ARMED. A pixel whose write is pending still completes.
- snap and frame end in the same cycle: the snap is kept armed for the next frame.
- busy = (state == CAPTURE).

Test Plan:
- Params X=4, Y=3, DEC=1, fmt=2, continuous: a frame of 3 lines × 4 pixels, pixel=16'hF81F → 12 px_wr pulses, addr 0..11, data 12'hF0F, one frame_done, frame_count=1.
- DEC_X=2, DEC_Y=2, source 8×6 with pixel value = column index → 12 writes of only even columns from even rows; addr 0..11 contiguous.
- fmt=0 vs fmt=1 with pixel 16'hFFE0 → data 3'b110 (12'h006) and 8'hFC (12'h0FC) respectively.
- single=1, no snap: two frames → zero px_wr, busy=0. snap pulse, then two frames → only the first is captured, frame_count increments once.
- Line with an odd byte count (7 bytes) → 3 writes from that line, line_err=1; next frame start clears it.
- Reset asserted mid-line after 5 writes → outputs 0 immediately. Capture restarts at addr 0 on the next full vsync cycle.

Source files
------------

// File: rtl/cam_capture_scaled.sv
// OV7670 RGB565 byte stream to decimated, depth-reduced pixels written into a frame buffer.
// Continuous or single-shot capture, frame counting and odd-line error flag.
module cam_capture_scaled #(
    parameter int CAM_SCREEN_X = 160,
    parameter int CAM_SCREEN_Y = 120,
    parameter int AW           = 15,
    parameter int DW           = 12,
    parameter int DEC_X        = 4,
    parameter int DEC_Y        = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          vsync,
    input  logic          href,
    input  logic [7:0]    data,
    input  logic [1:0]    fmt,
    input  logic          single,
    input  logic          snap,
    output logic [AW-1:0] mem_px_addr,
    output logic [DW-1:0] mem_px_data,
    output logic          px_wr,
    output logic          frame_done,
    output logic [7:0]    frame_count,
    output logic          busy,
    output logic          line_err
);
    localparam int CW = $clog2(CAM_SCREEN_X + 1);
    localparam int RW = $clog2(CAM_SCREEN_Y + 1);
    localparam logic [2:0]    DXM      = 3'(DEC_X - 1);
    localparam logic [2:0]    DYM      = 3'(DEC_Y - 1);
    localparam logic [CW-1:0] SX       = CW'(CAM_SCREEN_X);
    localparam logic [RW-1:0] SY       = RW'(CAM_SCREEN_Y);
    localparam logic [AW-1:0] ROW_STEP = AW'(CAM_SCREEN_X);

    typedef enum logic [1:0] {S_WAIT_VS, S_ARMED, S_IDLE_SNAP, S_CAPTURE} state_t;
    state_t r_state, w_next;

    logic          r_vs_d, r_href_d, r_armed, r_phase;
    logic [7:0]    r_hi;
    logic [1:0]    r_fmt;
    logic [2:0]    r_dx, r_dy;
    logic [CW-1:0] r_scol;
    logic [RW-1:0] r_srow;
    logic [AW-1:0] r_row_base;

    logic          w_vs_rise, w_vs_fall, w_href_fall, w_armed;
    logic          w_start, w_eof, w_px, w_keep;
    logic [4:0]    w_r, w_b;
    logic [5:0]    w_g;
    logic [11:0]   w_pix;

    assign w_vs_rise   = vsync & ~r_vs_d;
    assign w_vs_fall   = ~vsync & r_vs_d;
    assign w_href_fall = r_href_d & ~href;
    assign w_armed     = r_armed | snap;
    assign w_start     = (r_state == S_ARMED) && w_vs_fall;
    assign w_eof       = (r_state == S_CAPTURE) && w_vs_rise;
    assign w_px        = (r_state == S_CAPTURE) && href && r_phase;
    assign w_keep      = w_px && (r_dx == 3'd0) && (r_dy == 3'd0) &&
                         (r_scol < SX) && (r_srow < SY);
    assign busy        = (r_state == S_CAPTURE);

    assign w_r = r_hi[7:3];
    assign w_g = {r_hi[2:0], data[7:5]};
    assign w_b = data[4:0];

    always_comb begin
        case (r_fmt)
            2'd0:    w_pix = {9'd0, w_r[4], w_g[5], w_b[4]};
            2'd1:    w_pix = {4'd0, w_r[4:2], w_g[5:3], w_b[4:3]};
            default: w_pix = {w_r[4:1], w_g[5:2], w_b[4:1]};
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_WAIT_VS:   if (vsync) w_next = S_ARMED;
            S_ARMED:     if (w_vs_fall) w_next = (!single || w_armed) ? S_CAPTURE : S_IDLE_SNAP;
            S_IDLE_SNAP: if (w_armed) w_next = S_WAIT_VS;
            S_CAPTURE:   if (w_vs_rise) w_next = S_WAIT_VS;
            default:     w_next = S_WAIT_VS;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_WAIT_VS;
        else      r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vs_d      <= 1'b0;
            r_href_d    <= 1'b0;
            r_armed     <= 1'b0;
            r_phase     <= 1'b0;
            r_hi        <= '0;
            r_fmt       <= '0;
            r_dx        <= '0;
            r_dy        <= '0;
            r_scol      <= '0;
            r_srow      <= '0;
            r_row_base  <= '0;
            mem_px_addr <= '0;
            mem_px_data <= '0;
            px_wr       <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= '0;
            line_err    <= 1'b0;
        end else begin
            r_vs_d     <= vsync;
            r_href_d   <= href;
            px_wr      <= w_keep;
            frame_done <= w_eof;

            // A snap landing on the frame-end cycle survives into the next frame.
            if (w_eof) begin
                frame_count <= frame_count + 8'd1;
                r_armed     <= snap;
            end else if (snap) begin
                r_armed <= 1'b1;
            end

            if (w_keep) begin
                mem_px_addr <= r_row_base + AW'(r_scol);
                mem_px_data <= DW'(w_pix);
            end

            if (w_start) begin
                r_fmt      <= fmt;
                r_phase    <= 1'b0;
                r_dx       <= '0;
                r_dy       <= '0;
                r_scol     <= '0;
                r_srow     <= '0;
                r_row_base <= '0;
                line_err   <= 1'b0;
            end else if (r_state == S_CAPTURE) begin
                if (href) begin
                    r_phase <= ~r_phase;
                    if (!r_phase) begin
                        r_hi <= data;
                    end else begin
                        r_dx <= (r_dx == DXM) ? 3'd0 : r_dx + 3'd1;
                        if (r_dx == DXM && r_scol < SX) r_scol <= r_scol + CW'(1);
                    end
                end else if (w_href_fall) begin
                    r_phase <= 1'b0;
                    r_dx    <= '0;
                    r_scol  <= '0;
                    if (r_phase) line_err <= 1'b1;
                    r_dy <= (r_dy == DYM) ? 3'd0 : r_dy + 3'd1;
                    // Row base steps by a full stored line so short lines keep later rows aligned.
                    if (r_dy == DYM && r_srow < SY) begin
                        r_srow     <= r_srow + RW'(1);
                        r_row_base <= r_row_base + ROW_STEP;
                    end
                end
            end
        end
    end
endmodule
